cordic_pipe_param: RTL and testbench

Fully registered, parametrised CORDIC engine. It supports both rotation mode (sin/cos, polar-to-rectangular) and vectoring mode (magnitude/atan2). The mode is selected per sample and carried down the pipeline with a user tag. There is one register per micro-rotation, a ready/valid handshake with global stall, and quadrant pre-correction built into stage 0. It is the generalised engine behind the sine/cosine generator and future magnitude/phase users.

---
 rtl/cordic_pipe_param.sv | 128 ++++++++++++
 tb/tb_cordic_pipe_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe_param.sv
// cordic_pipe_param: fully registered rotation/vectoring CORDIC with per-sample mode, tag and global stall
// Ports: Clk, Reset (sync, active-high); In_valid/In_ready, In_mode (0 rot, 1 vec), In_x, In_y, In_z, In_tag;
//        Out_valid/Out_ready, Out_x, Out_y (WIDTH+2), Out_z, Out_mode, Out_tag.
// Macro CORDIC_GAIN_COMP_EN adds one register stage scaling x/y by K = 19898/2^15 (latency STAGES+2).
module cordic_pipe_param #(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int STAGES      = 16,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         In_valid,
  output logic                         In_ready,
  input  logic                         In_mode,
  input  logic signed [WIDTH-1:0]      In_x,
  input  logic signed [WIDTH-1:0]      In_y,
  input  logic signed [ANGLE_WIDTH-1:0] In_z,
  input  logic [TAG_WIDTH-1:0]         In_tag,
  output logic                         Out_valid,
  input  logic                         Out_ready,
  output logic signed [WIDTH+1:0]      Out_x,
  output logic signed [WIDTH+1:0]      Out_y,
  output logic signed [ANGLE_WIDTH-1:0] Out_z,
  output logic                         Out_mode,
  output logic [TAG_WIDTH-1:0]         Out_tag
);
  localparam int XW = WIDTH + 2;
  localparam int AW = ANGLE_WIDTH;
  // atan(2^-i) in binary angle units; Taylor series is exact enough for t <= 1/2, i = 0 is pi/4
  function automatic logic [STAGES*AW-1:0] atan_tab();
    logic [STAGES*AW-1:0] r;
    real t, s, p, pi, sc;
    r = '0;
    pi = 3.14159265358979323846;
    sc = 1.0;
    for (int k = 1; k < AW; k++) sc = sc * 2.0;
    t = 1.0;
    for (int i = 0; i < STAGES; i++) begin
      s = 0.0;
      p = t;
      for (int k = 0; k < 60; k++) begin
        s = s + ((k % 2 == 1) ? -p : p) / (2 * k + 1);
        p = p * t * t;
      end
      if (i == 0) s = pi / 4.0;
      r[i*AW +: AW] = AW'($rtoi(s / pi * sc + 0.5));
      t = t / 2.0;
    end
    return r;
  endfunction
  localparam logic [STAGES*AW-1:0] ATAN = atan_tab();
  logic                  advance, flip;
  logic signed [XW-1:0]  xe, ye;
  logic                  v [0:STAGES];
  logic                  m [0:STAGES];
  logic [TAG_WIDTH-1:0]  t [0:STAGES];
  logic signed [XW-1:0]  x [0:STAGES];
  logic signed [XW-1:0]  y [0:STAGES];
  logic signed [AW-1:0]  z [0:STAGES];
  logic signed [XW-1:0]  xn [0:STAGES-1];
  logic signed [XW-1:0]  yn [0:STAGES-1];
  logic signed [AW-1:0]  zn [0:STAGES-1];
  assign advance  = !Out_valid || Out_ready;
  assign In_ready = advance;
  assign xe = XW'(In_x);
  assign ye = XW'(In_y);
  // fold the input into the right half-plane so every micro-rotation sequence converges
  assign flip = In_mode ? In_x[WIDTH-1] : (In_z[AW-1] ^ In_z[AW-2]);
  for (genvar g = 0; g < STAGES; g++) begin : stg
    logic up;
    assign up    = m[g] ? y[g][XW-1] : !z[g][AW-1];
    assign xn[g] = up ? x[g] - (y[g] >>> g) : x[g] + (y[g] >>> g);
    assign yn[g] = up ? y[g] + (x[g] >>> g) : y[g] - (x[g] >>> g);
    assign zn[g] = up ? z[g] - ATAN[g*AW +: AW] : z[g] + ATAN[g*AW +: AW];
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      for (int i = 0; i <= STAGES; i++) begin
        v[i] <= 1'b0;
        m[i] <= 1'b0;
        t[i] <= '0;
        x[i] <= '0;
        y[i] <= '0;
        z[i] <= '0;
      end
    end else if (advance) begin
      v[0] <= In_valid;
      m[0] <= In_mode;
      t[0] <= In_tag;
      x[0] <= flip ? -xe : xe;
      y[0] <= flip ? -ye : ye;
      z[0] <= flip ? {~In_z[AW-1], In_z[AW-2:0]} : In_z;
      for (int i = 0; i < STAGES; i++) begin
        v[i+1] <= v[i];
        m[i+1] <= m[i];
        t[i+1] <= t[i];
        x[i+1] <= xn[i];
        y[i+1] <= yn[i];
        z[i+1] <= zn[i];
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
  always_ff @(posedge Clk)
    if (Reset) begin
      Out_valid <= 1'b0;
      Out_mode  <= 1'b0;
      Out_tag   <= '0;
      Out_x     <= '0;
      Out_y     <= '0;
      Out_z     <= '0;
    end else if (advance) begin
      Out_valid <= v[STAGES];
      Out_mode  <= m[STAGES];
      Out_tag   <= t[STAGES];
      Out_x     <= XW'(((XW+16)'(x[STAGES]) * (XW+16)'(19898) + (XW+16)'(16384)) >>> 15);
      Out_y     <= XW'(((XW+16)'(y[STAGES]) * (XW+16)'(19898) + (XW+16)'(16384)) >>> 15);
      Out_z     <= z[STAGES];
    end
`else
  assign Out_valid = v[STAGES];
  assign Out_mode  = m[STAGES];
  assign Out_tag   = t[STAGES];
  assign Out_x     = x[STAGES];
  assign Out_y     = y[STAGES];
  assign Out_z     = z[STAGES];
`endif
endmodule

// File: tb/tb_cordic_pipe_param.sv
// tb_cordic_pipe_param: table and scoreboard bench for the CORDIC pipeline against a real-math model
module tb_cordic_pipe_param;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif
  localparam real PI = 3.14159265358979323846;
  localparam int TOL_XY = 8;
  localparam int TOL_Z = 2;
  typedef struct {
    bit  mode;
    int  x, y, z;
    real ex, ey;
    int  ez;
  } vec_t;
  typedef struct {
    int ex, ey, ez, tag, acc;
    bit mode, lat;
  } sb_t;
  logic               Clk = 1'b0;
  logic               Reset, In_valid, In_ready, In_mode, Out_valid, Out_ready, Out_mode;
  logic signed [15:0] In_x, In_y, In_z, Out_z;
  logic [3:0]         In_tag, Out_tag;
  logic signed [17:0] Out_x, Out_y;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  real  g;
  sb_t  cur;
  sb_t  sb[$];
  vec_t tbl[10];
  cordic_pipe_param dut (
    .Clk(Clk), .Reset(Reset),
    .In_valid(In_valid), .In_ready(In_ready), .In_mode(In_mode),
    .In_x(In_x), .In_y(In_y), .In_z(In_z), .In_tag(In_tag),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_x(Out_x), .Out_y(Out_y), .Out_z(Out_z), .Out_mode(Out_mode), .Out_tag(Out_tag)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic int rnd(input real r);
    return $rtoi(r < 0.0 ? r - 0.5 : r + 0.5);
  endfunction
  function automatic int wrap16(input int a);
    logic signed [15:0] w;
    w = 16'(a);
    return int'(w);
  endfunction
  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask
  task automatic chkz(input string name, input int act, input int exp);
    int dz;
    dz = wrap16(act - exp);
    checks++;
    if (dz > TOL_Z || dz < -TOL_Z) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d mod 2^16) at cycle %0d", name, act, exp, TOL_Z, cyc);
    end
  endtask
  function automatic void model(input bit md, input int x, input int y, input int z,
                                output real ex, output real ey, output int ez);
    real th;
    if (md) begin
      ex = $sqrt(real'(x) * x + real'(y) * y);
      ey = 0.0;
      ez = wrap16(rnd(real'(z) + $atan2(real'(y), real'(x)) * 32768.0 / PI));
    end else begin
      th = real'(z) * PI / 32768.0;
      ex = x * $cos(th) - y * $sin(th);
      ey = x * $sin(th) + y * $cos(th);
      ez = 0;
    end
  endfunction
  always @(negedge Clk) begin
    sb_t e;
    if (!Reset) begin
      if (Out_valid && Out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: tag %0d x %0d with empty scoreboard at cycle %0d", Out_tag, Out_x, cyc);
        end else begin
          e = sb.pop_front();
          chk("out_tag", int'(Out_tag), e.tag, 0);
          chk("out_mode", int'(Out_mode), int'(e.mode), 0);
          chk("out_x", int'(Out_x), e.ex, TOL_XY);
          chk("out_y", int'(Out_y), e.ey, TOL_XY);
          chkz("out_z", int'(Out_z), e.ez);
          if (e.lat) chk("latency", cyc - e.acc, LAT, 0);
        end
      end
      if (In_valid && In_ready) begin
        e = cur;
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  end
  task automatic send(input bit md, input int x, input int y, input int z, input int tag,
                      input real ex, input real ey, input int ez, input bit lat);
    int n;
    cur.mode = md;
    cur.tag  = tag % 16;
    cur.ex   = rnd(g * ex);
    cur.ey   = rnd(g * ey);
    cur.ez   = ez;
    cur.lat  = lat;
    In_valid = 1'b1;
    In_mode  = md;
    In_x     = 16'(x);
    In_y     = 16'(y);
    In_z     = 16'(z);
    In_tag   = 4'(tag);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!In_ready && n < 200);
    if (!In_ready) begin
      errors++;
      $display("FAIL accept_timeout: In_ready stuck at 0 for %0d cycles", n);
    end
    @(posedge Clk);
    #1;
  endtask
  task automatic send_rand(input int tag, input bit md);
    int x, y, z, ez;
    real ex, ey;
    if (md) begin
      x = ($urandom_range(0, 1) == 1 ? 1 : -1) * int'($urandom_range(3000, 12000));
      y = ($urandom_range(0, 1) == 1 ? 1 : -1) * int'($urandom_range(3000, 12000));
    end else begin
      x = int'($urandom_range(0, 24000)) - 12000;
      y = int'($urandom_range(0, 24000)) - 12000;
    end
    z = int'($urandom_range(0, 65535)) - 32768;
    model(md, x, y, z, ex, ey, ez);
    send(md, x, y, z, tag, ex, ey, ez, 1'b0);
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk(name, sb.size(), 0, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt;
    int xs, ys, zs, ts;
    // expected values at unit gain; the bench applies the CORDIC gain itself
    tbl[0] = '{1'b0, 16384, 0, 0, 16384.0, 0.0, 0};
    tbl[1] = '{1'b0, 16384, 0, 16384, 0.0, 16384.0, 0};
    tbl[2] = '{1'b0, 16384, 0, -32768, -16384.0, 0.0, 0};
    tbl[3] = '{1'b1, 10000, 10000, 0, 14142.1356, 0.0, 8192};
    tbl[4] = '{1'b1, -10000, 0, 0, 10000.0, 0.0, -32768};
    tbl[5] = '{1'b0, 0, 16384, 0, 0.0, 16384.0, 0};
    tbl[6] = '{1'b0, 16384, 0, -16384, 0.0, -16384.0, 0};
    tbl[7] = '{1'b1, 0, -12000, 100, 12000.0, 0.0, -16284};
    tbl[8] = '{1'b0, -32768, 0, 0, -32768.0, 0.0, 0};
    tbl[9] = '{1'b1, -32768, -32768, 0, 46340.9500, 0.0, -24576};
    g = 1.0;
    for (int i = 0; i < 16; i++) g = g * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef CORDIC_GAIN_COMP_EN
    g = g * 19898.0 / 32768.0;
`endif
    Reset = 1'b1;
    In_valid = 1'b0;
    In_mode = 1'b0;
    In_x = '0;
    In_y = '0;
    In_z = '0;
    In_tag = '0;
    Out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_out_valid", int'(Out_valid), 0, 0);
    chk("rst_in_ready", int'(In_ready), 1, 0);
    chk("rst_out_x", int'(Out_x), 0, 0);
    chk("rst_out_y", int'(Out_y), 0, 0);
    chk("rst_out_z", int'(Out_z), 0, 0);
    chk("rst_out_tag", int'(Out_tag), 0, 0);
    @(posedge Clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].z, i, tbl[i].ex, tbl[i].ey, tbl[i].ez, 1'b1);
      In_valid = 1'b0;
      drain("table_drain");
    end
    fork
      for (int k = 0; k < 20; k++) send_rand(k, bit'(k % 2));
      begin
        repeat (18) @(posedge Clk);
        #1 Out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge Clk);
          chk("stall_in_ready", int'(In_ready), 0, 0);
          chk("stall_out_valid", int'(Out_valid), 1, 0);
          if (k == 0) begin
            xs = int'(Out_x);
            ys = int'(Out_y);
            zs = int'(Out_z);
            ts = int'(Out_tag);
          end else begin
            chk("stall_hold_x", int'(Out_x), xs, 0);
            chk("stall_hold_y", int'(Out_y), ys, 0);
            chk("stall_hold_z", int'(Out_z), zs, 0);
            chk("stall_hold_tag", int'(Out_tag), ts, 0);
          end
        end
        @(posedge Clk);
        #1 Out_ready = 1'b1;
      end
    join
    In_valid = 1'b0;
    drain("stream_drain");
    for (int k = 0; k < 16; k++) send_rand(k, bit'(k % 2));
    Reset = 1'b1;
    In_valid = 1'b0;
    sb.delete();
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("midrst_out_valid", int'(Out_valid), 0, 0);
    chk("midrst_in_ready", int'(In_ready), 1, 0);
    cnt = 0;
    repeat (25) begin
      @(negedge Clk);
      if (Out_valid) cnt++;
    end
    chk("midrst_no_stale", cnt, 0, 0);
    @(posedge Clk);
    #1;
    send(tbl[0].mode, tbl[0].x, tbl[0].y, tbl[0].z, 7, tbl[0].ex, tbl[0].ey, tbl[0].ez, 1'b1);
    In_valid = 1'b0;
    drain("post_reset_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
